// File: rtl/spi_pkg.sv
// Shared definitions for the multi-word SPI slave: mode encodings,
// FSM state type and a constant-width helper.
package spi_pkg;

   // {CPOL, CPHA} for the four standard SPI modes
   localparam logic [1:0] SPI_MODE0 = 2'b00;
   localparam logic [1:0] SPI_MODE1 = 2'b01;
   localparam logic [1:0] SPI_MODE2 = 2'b10;
   localparam logic [1:0] SPI_MODE3 = 2'b11;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } spi_state_e;

   // Ceiling log2, used to size counters from parameters
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchroniser for one asynchronous SPI pin. The reset value
// matches the idle level of the pin so no false edge appears after reset.
module spi_sync #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RST_VAL     = 1'b0
) (
   input  logic clk_i,
   input  logic rstn_i,
   input  logic d_i,
   output logic q_o
);

   logic [SYNC_STAGES-1:0] sync_q;

   // Shift the pin level through the synchroniser chain
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) sync_q <= {SYNC_STAGES{RST_VAL}};
      else         sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
   end

   assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_slave_mw.sv
// Oversampling SPI slave: any CPOL/CPHA mode, parametrised word width and
// bit order, multi-word bursts under one chip-select assertion.
module spi_slave_mw
   import spi_pkg::*;
#(
   parameter int   WIDTH       = 8,
   parameter logic CPOL        = 1'b0,
   parameter logic CPHA        = 1'b0,
   parameter logic MSB_FIRST   = 1'b1,
   parameter int   SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             sclk,
   input  logic             mosi,
   input  logic             csn,
   output logic             miso,
   output logic             miso_oe,
   input  logic [WIDTH-1:0] send,
   output logic             send_ack,
   output logic [WIDTH-1:0] recv,
   output logic             output_valid,
   output logic             frame_start,
   output logic             frame_end,
   output logic             frame_err
);

   localparam int                CNT_W     = clog2(WIDTH);
   localparam int                INIT_W    = clog2(SYNC_STAGES + 1);
   localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(WIDTH - 1);
   localparam logic [INIT_W-1:0] INIT_DONE = INIT_W'(SYNC_STAGES);

   logic sclk_s, mosi_s, csn_s;
   logic sclk_prev_q, csn_prev_q;
   logic lead_edge, trail_edge, sample_edge, shift_edge, csn_fall, csn_rise;

   spi_state_e        state_q, state_d;
   logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [WIDTH-1:0]  rx_q, rx_d, tx_q, tx_d, recv_q, recv_d;
   logic              miso_q, miso_d, first_q, first_d;
   logic              ovalid_q, ovalid_d, ack_q, ack_d;
   logic              fstart_q, fstart_d, fend_q, fend_d, ferr_q, ferr_d;
   logic [INIT_W-1:0] init_cnt_q, init_cnt_d;
   logic              armed_q, armed_d;

   // Bit currently presented on MISO
   function automatic logic head(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? w[WIDTH-1] : w[0];
   endfunction

   // Move the next TX bit into the head position
   function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
   endfunction

   // Append a received bit so that the first bit ends up in the right place
   function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] w, input logic b);
      return MSB_FIRST ? {w[WIDTH-2:0], b} : {b, w[WIDTH-1:1]};
   endfunction

   spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sync_sclk (
      .clk_i(clk), .rstn_i(rstn), .d_i(sclk), .q_o(sclk_s));
   spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
      .clk_i(clk), .rstn_i(rstn), .d_i(mosi), .q_o(mosi_s));
   spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_csn (
      .clk_i(clk), .rstn_i(rstn), .d_i(csn), .q_o(csn_s));

   assign lead_edge   = (sclk_s != CPOL) && (sclk_prev_q == CPOL);
   assign trail_edge  = (sclk_s == CPOL) && (sclk_prev_q != CPOL);
   assign sample_edge = CPHA ? trail_edge : lead_edge;
   assign shift_edge  = CPHA ? lead_edge  : trail_edge;
   // A frame may only start once csn has been seen high after reset, so a
   // frame that was already running when reset released is ignored.
   assign csn_fall    = armed_q && csn_prev_q && !csn_s;
   assign csn_rise    = !csn_prev_q && csn_s;

   // Arm after the synchronisers hold real pin values and csn reads high
   always_comb begin
      init_cnt_d = init_cnt_q;
      armed_d    = armed_q;
      if (init_cnt_q != INIT_DONE) init_cnt_d = init_cnt_q + 1'b1;
      else if (csn_s)              armed_d    = 1'b1;
   end

   // Frame FSM, bit counter, shifters and pulse generation
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      rx_d      = rx_q;
      tx_d      = tx_q;
      miso_d    = miso_q;
      recv_d    = recv_q;
      first_d   = first_q;
      ovalid_d  = 1'b0;
      ack_d     = 1'b0;
      fstart_d  = 1'b0;
      fend_d    = 1'b0;
      ferr_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            miso_d = 1'b0;
            if (csn_fall) begin
               state_d   = ACTIVE;
               fstart_d  = 1'b1;
               ack_d     = 1'b1;
               tx_d      = send;
               bit_cnt_d = '0;
               // CPHA=0 must present the first bit before the first edge
               first_d   = CPHA;
               miso_d    = CPHA ? 1'b0 : head(send);
            end
         end
         ACTIVE: begin
            if (csn_rise) begin
               // csn wins over a coincident final sample edge
               state_d   = IDLE;
               fend_d    = 1'b1;
               ferr_d    = (bit_cnt_q != '0);
               bit_cnt_d = '0;
               miso_d    = 1'b0;
            end else if (sample_edge) begin
               rx_d = shift_in(rx_q, mosi_s);
               if (bit_cnt_q == LAST_BIT) begin
                  bit_cnt_d = '0;
                  recv_d    = rx_d;
                  ovalid_d  = 1'b1;
                  // Next word of a burst: its first bit goes out on the next shift edge
                  tx_d      = send;
                  ack_d     = 1'b1;
                  first_d   = 1'b1;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end else if (shift_edge) begin
               if (first_q) begin
                  miso_d  = head(tx_q);
                  first_d = 1'b0;
               end else begin
                  tx_d   = advance(tx_q);
                  miso_d = head(tx_d);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= IDLE;
         bit_cnt_q   <= '0;
         rx_q        <= '0;
         tx_q        <= '0;
         miso_q      <= 1'b0;
         recv_q      <= '0;
         first_q     <= 1'b0;
         ovalid_q    <= 1'b0;
         ack_q       <= 1'b0;
         fstart_q    <= 1'b0;
         fend_q      <= 1'b0;
         ferr_q      <= 1'b0;
         sclk_prev_q <= CPOL;
         csn_prev_q  <= 1'b1;
         init_cnt_q  <= '0;
         armed_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         rx_q        <= rx_d;
         tx_q        <= tx_d;
         miso_q      <= miso_d;
         recv_q      <= recv_d;
         first_q     <= first_d;
         ovalid_q    <= ovalid_d;
         ack_q       <= ack_d;
         fstart_q    <= fstart_d;
         fend_q      <= fend_d;
         ferr_q      <= ferr_d;
         sclk_prev_q <= sclk_s;
         csn_prev_q  <= csn_s;
         init_cnt_q  <= init_cnt_d;
         armed_q     <= armed_d;
      end
   end

   assign miso_oe      = !csn_s;
   assign miso         = miso_oe & miso_q;
   assign send_ack     = ack_q;
   assign recv         = recv_q;
   assign output_valid = ovalid_q;
   assign frame_start  = fstart_q;
   assign frame_end    = fend_q;
   assign frame_err    = ferr_q;

endmodule
